// File: rtl/mips_pkg.sv
// mips_pkg: shared op/state encodings and helpers for the mul/div unit
package mips_pkg;
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;
  localparam int MD_ITERS = 32;
  function automatic logic md_is_div(input logic [1:0] o);
    return o == MD_DIVU || o == MD_DIV;
  endfunction
  function automatic logic md_is_signed(input logic [1:0] o);
    return o == MD_MULT || o == MD_DIV;
  endfunction
endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: operand magnitudes on entry and result sign correction on exit
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  input  logic               neg_p,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem
);
  always_comb begin
    abs_a = sgn && a[WIDTH-1] ? -a : a;
    abs_b = sgn && b[WIDTH-1] ? -b : b;
    prod  = neg_p ? -acc : acc;
    quo   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU owning the HI/LO register pair
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(MD_ITERS);
  md_state_e state, next;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0] mc, abs_a, abs_b, quo, rem;
  logic [WIDTH:0] sum, diff;
  logic div_q, sa, sb, load, iter, fin;
  // a zero divisor keeps the all-ones quotient and recovers a as the remainder
  md_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .sgn   (md_is_signed(op)),
    .a     (a),
    .b     (b),
    .abs_a (abs_a),
    .abs_b (abs_b),
    .neg_p (sa ^ sb),
    .neg_q ((sa ^ sb) && mc != '0),
    .neg_r (sa),
    .acc   (acc),
    .prod  (prod),
    .quo   (quo),
    .rem   (rem)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (start ? CALC : IDLE) :
           state == CALC ? (cnt == CW'(MD_ITERS - 1) ? FIX : CALC) : IDLE;
  always_comb begin
    load = state == IDLE && start;
    iter = state == CALC;
    fin  = state == FIX;
  end
  // multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : '0);
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mc};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {busy, done, div_by_zero, div_q, sa, sb} <= '0;
      cnt <= '0;
      acc <= '0;
      mc  <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      busy <= next != IDLE;
      done <= fin;
      if (load) begin
        div_q       <= md_is_div(op);
        sa          <= md_is_signed(op) && a[WIDTH-1];
        sb          <= md_is_signed(op) && b[WIDTH-1];
        mc          <= md_is_div(op) ? abs_b : abs_a;
        acc         <= {{WIDTH{1'b0}}, md_is_div(op) ? abs_a : abs_b};
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end
      if (iter) begin
        cnt <= cnt + 1'b1;
        acc <= div_q ? (diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                     : {sum, acc[WIDTH-1:1]};
      end
      if (fin) begin
        {hi, lo}    <= div_q ? {rem, quo} : prod;
        div_by_zero <= div_q && mc == '0;
      end
      if (state == IDLE && !start) begin
        if (wr_hi) hi <= a;
        if (wr_lo) lo <= a;
      end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit
module tb_mul_div_unit;
  import mips_pkg::*;
  logic clk, rst_n, start, wr_hi, wr_lo, busy, done, div_by_zero;
  logic [1:0] op;
  logic [31:0] a, b, hi, lo, saved_hi;
  int checks = 0, errors = 0, n_done;
  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic finish_op(input string tag, input int n0, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed);
    int n = n0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " latency"}, n, 33);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " dz"}, div_by_zero, ed);
    check({tag, " busy_end"}, busy, 0);
    @(posedge clk);
    #1 check({tag, " done_drop"}, done, 0);
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed);
    launch(o, x, y);
    check({tag, " busy"}, busy, 1);
    check({tag, " dz_clr"}, div_by_zero, 0);
    finish_op(tag, 0, eh, el, ed);
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst dz", div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) begin wr_lo = 1'b1; a = 32'h12345678; end
    @(posedge clk);
    #1 wr_lo = 1'b0;
    check("mtlo lo", lo, 32'h12345678);
    check("mtlo hi", hi, 0);
    @(negedge clk) begin wr_hi = 1'b1; a = 32'hCAFEF00D; end
    @(posedge clk);
    #1 wr_hi = 1'b0;
    check("mthi hi", hi, 32'hCAFEF00D);
    @(negedge clk) begin wr_hi = 1'b1; wr_lo = 1'b1; a = 32'h0BADBEEF; end
    @(posedge clk);
    #1 begin wr_hi = 1'b0; wr_lo = 1'b0; end
    check("both hi", hi, 32'h0BADBEEF);
    check("both lo", lo, 32'h0BADBEEF);
    @(negedge clk) begin
      start = 1'b1; wr_hi = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd5;
    end
    @(posedge clk);
    #1 begin start = 1'b0; wr_hi = 1'b0; end
    check("start_wr hi", hi, 32'h0BADBEEF);
    finish_op("start_wr", 0, 32'h0, 32'd15, 1'b0);
    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg", MD_MULT, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mult_min", MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_neg", MD_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("divu_z", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    run_op("divu_6_3", MD_DIVU, 32'd6, 32'd3, 32'd0, 32'd2, 1'b0);
    run_op("div_z", MD_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    saved_hi = hi;
    launch(MD_MULTU, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1 begin
      start = 1'b1; wr_hi = 1'b1; op = MD_DIVU; a = 32'hDEADDEAD; b = 32'd7;
    end
    @(posedge clk);
    #1 begin start = 1'b0; wr_hi = 1'b0; end
    check("busy_hold hi", hi, saved_hi);
    check("busy_hold busy", busy, 1);
    finish_op("ignore", 5, 32'h0, 32'd42, 1'b0);
    launch(MD_MULTU, 32'hFFFFFFFF, 32'd2);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst hi", hi, 0);
    check("midrst lo", lo, 0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) rst_n = 1'b1;
      n_done += int'(done);
    end
    check("midrst no_done", n_done, 0);
    check("midrst idle", busy, 0);
    run_op("after_rst", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU and owning the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle sequence and exposes HI/LO for MFHI/MFLO. It also accepts direct HI/LO writes for MTHI/MTLO. A start/busy/done handshake lets the control unit stall until results are ready.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch an operation; sampled only while idle
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  multiplicand or dividend (rs)
- b  in  WIDTH  multiplier or divisor (rt)
- wr_hi  in  1  MTHI: load hi from a; honoured only while idle
- wr_lo  in  1  MTLO: load lo from a; honoured only while idle
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi and lo hold the new result
- div_by_zero  out  1  set with done when a DIV or DIVU had b == 0; cleared by the next accepted start
- hi  out  WIDTH  HI register: upper product half, or remainder
- lo  out  WIDTH  LO register: lower product half, or quotient

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - With start = 1, latch op, a, b and the operand signs, then go to CALC with iteration count 0.
  - Signed ops (MULT, DIV) use operand magnitudes internally.
- CALC: one iteration per cycle, 32 iterations, then go to FIX.
  - Multiply: shift-add over the 64-bit accumulator.
  - Divide: restoring shift-subtract, giving a 32-bit quotient and remainder.
- FIX: apply the sign correction, write hi/lo, pulse done, return to IDLE.
- Multiply result: 64-bit product; hi = bits 63:32, lo = bits 31:0.
  - MULT: the product is negated when the operand signs differ.
- DIV sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, no flag.
- Divide by zero (b == 0, DIVU or DIV): lo = 0xFFFFFFFF, hi = a unmodified, div_by_zero = 1. Full latency still applies.
- While busy:
  - start is ignored.
  - wr_hi and wr_lo are ignored.
  - hi and lo keep their old values until FIX.
- In IDLE, start together with wr_hi or wr_lo: start wins and the writes are dropped.
- wr_hi and wr_lo together: both registers load a.
- Reset (any time, including mid-operation):
  - state returns to IDLE and any operation is aborted;
  - hi = lo = 0;
  - busy = done = div_by_zero = 0.

## Timing
- Cycle numbering: start is sampled at edge E.
  - Iterations occur at edges E+1 through E+32.
  - hi, lo, done and div_by_zero update at edge E+33; done drops at E+34.
- busy is registered: high after edge E, low after edge E+33.
- Earliest next start is sampled at E+34, giving a throughput of one operation per 34 cycles.
- wr_hi and wr_lo take effect at the sampling edge; the value is visible on hi/lo the next cycle.
- All outputs come directly from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package mips_pkg holds:
  - op encodings MD_MULTU, MD_MULT, MD_DIVU, MD_DIV;
  - the state encoding;
  - the iteration-count constant 32.
- Sub-module md_sign_fix (combinational): abs-value of operands on entry, and conditional negation of product, quotient and remainder in FIX. It is shared by the multiply and divide paths.
- The iteration counter, the 64-bit accumulator/remainder register and the FSM live in the top module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; done exactly at E+33; busy low in the cycle after.
- MULT −3 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIVU 100 / 7 → lo = 14, hi = 2. DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5, div_by_zero = 1 with done. A following DIVU 6 / 3 clears the flag at its start.
- Handshake checks:
  - start pulsed at E+5 with different operands → ignored; the original result is returned.
  - wr_hi during busy → ignored.
  - In IDLE, wr_lo with a = 0x12345678 → lo = 0x12345678 next cycle.
  - start plus wr_hi in the same cycle → operation runs and hi is not loaded.
- Reset asserted at E+10 → immediately busy = 0, hi = lo = 0, done never pulses. After release, a new MULTU 3 × 4 gives lo = 12, hi = 0.
